mux_2to1: RTL and testbench
===========================

# mux_2to1

32-bit two-input data selector for the MIPS datapath, used wherever one of two operand or result buses must be chosen: ALU source, register-write data, next-PC. The primary output is purely combinational and valid without any clock activity. A registered, enable-gated copy of the selected word and of the select line is also provided, so pipeline stages can capture the choice at the clock edge.

## Interface
Parameters:
- WIDTH, 32, data bus width in bits (must be ≥1)

Ports (one clock; reset is asynchronous and active-low):
- Clk  input  1  rising-edge clock for the registered outputs only
- Rst_n  input  1  asynchronous active-low reset of all registers
- D1  input  WIDTH  data input selected when Sel=0
- D2  input  WIDTH  data input selected when Sel=1
- Sel  input  1  select line
- En  input  1  capture enable for registered outputs
- Dout  output  WIDTH  combinational selected word
- Dout_q  output  WIDTH  registered selected word
- Sel_q  output  1  registered select line
- Chg  output  1  one-cycle pulse when a capture alters Dout_q

## Operation
- Dout = D1 when Sel=0, D2 when Sel=1. No reset dependence, no clock dependence.
- Sel X/Z: Dout takes the bitwise merge. Bits where D1 and D2 agree pass through; differing bits are X in simulation. Synthesis needs no special handling.
- On a rising Clk edge with En=1: Dout_q ← Dout, Sel_q ← Sel.
- En=0: Dout_q and Sel_q hold.
- Chg registers (En=1 && Dout != Dout_q). It is 0 in any cycle with En=0.
- Rst_n=0, at any time and asynchronously: Dout_q=0, Sel_q=0, Chg=0. Dout is unaffected and keeps following its inputs.
- Rst_n deassertion is synchronized externally. The first capture occurs on the first rising edge with Rst_n=1 and En=1.

## Timing
- Dout: zero-cycle (combinational) latency from D1, D2, Sel.
- Dout_q, Sel_q, Chg: one-cycle latency from the inputs sampled at the capture edge.
- Simultaneous Sel and data change before an edge: the values settled at the edge are captured.
- Reset asserted mid-operation: registered outputs clear immediately, without waiting for Clk. Captures resume after release.
- No handshake. En is the sole qualifier.

## Structure
- Shared package mips_pkg: constant DATA_W = 32, used as the default for WIDTH, and the typedef word_t = logic [DATA_W-1:0].
- One sub-module is natural: dff_en_rn. It is a WIDTH-parameterized flop with enable and asynchronous active-low reset, instantiated for Dout_q and for {Sel_q}.
- Chg is inline logic.
- Selection logic is a single conditional assignment, not a separate module.

## Test plan
- Static select, no clock: D1=0, D2=1, Sel=0 → Dout=0. Hold 50 ns, then Sel=1 → Dout=1 immediately.
- Full-width pass: D1=32'hDEADBEEF, D2=32'h12345678; toggle Sel 0→1→0 → Dout follows exactly, all 32 bits checked.
- Capture with enable: Rst_n=1, En=1, Sel=1, D2=32'hA5A5A5A5 → after one edge Dout_q=32'hA5A5A5A5, Sel_q=1, Chg=1. Next edge with identical inputs → Chg=0.
- Hold: En=0, change D2 to 32'hFFFFFFFF → Dout=32'hFFFFFFFF while Dout_q stays 32'hA5A5A5A5 and Chg=0 across 3 edges.
- Async reset mid-run: drive Rst_n low between edges → Dout_q=0, Sel_q=0, Chg=0 before the next edge. Dout still equals the selected input.
- Sel=X with D1=D2=32'h0000FFFF → Dout=32'h0000FFFF (no X propagation on agreeing bits).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the MIPS core.
package mips_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/mux_2to1_if.sv
// Operand/result bus for the 2:1 selector: two data inputs, select, capture enable and outputs.
interface mux_2to1_if
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_W
) ();

   logic [WIDTH-1:0] D1;
   logic [WIDTH-1:0] D2;
   logic             Sel;
   logic             En;
   logic [WIDTH-1:0] Dout;
   logic [WIDTH-1:0] Dout_q;
   logic             Sel_q;
   logic             Chg;

   modport master (
      output D1, D2, Sel, En,
      input  Dout, Dout_q, Sel_q, Chg
   );

   modport slave (
      input  D1, D2, Sel, En,
      output Dout, Dout_q, Sel_q, Chg
   );

endinterface : mux_2to1_if

// File: rtl/dff_en_rn.sv
// Parameterized D flip-flop bank with capture enable and asynchronous active-low reset.
module dff_en_rn #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule : dff_en_rn

// File: rtl/mux_2to1.sv
// 32-bit two-input data selector with a combinational output and an enable-gated registered copy.
module mux_2to1
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input logic        Clk,
   input logic        Rst_n,
   mux_2to1_if.slave  bus
);

   logic [WIDTH-1:0] dout_sel;
   logic             chg_d;
   logic             chg_q;

   // A conditional operator merges D1/D2 bitwise when Sel is X, so agreeing bits stay known.
   assign dout_sel = bus.Sel ? bus.D2 : bus.D1;
   assign bus.Dout = dout_sel;

   dff_en_rn #(
      .WIDTH (WIDTH)
   ) u_dout_reg (
      .clk   (Clk),
      .rst_n (Rst_n),
      .en_i  (bus.En),
      .d_i   (dout_sel),
      .q_o   (bus.Dout_q)
   );

   dff_en_rn #(
      .WIDTH (1)
   ) u_sel_reg (
      .clk   (Clk),
      .rst_n (Rst_n),
      .en_i  (bus.En),
      .d_i   (bus.Sel),
      .q_o   (bus.Sel_q)
   );

   // Pulse only when this edge's capture actually changes the registered word.
   assign chg_d = bus.En && (dout_sel != bus.Dout_q);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         chg_q <= 1'b0;
      end else begin
         chg_q <= chg_d;
      end
   end

   assign bus.Chg = chg_q;

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed cases plus randomized capture traffic against a reference model.
module tb_mux_2to1;
   import mips_pkg::*;

   logic Clk;
   logic Rst_n;
   logic clk_run;

   int n_vec;
   int n_err;

   word_t m_q;
   logic  m_sel;
   logic  m_chg;

   mux_2to1_if #(.WIDTH(DATA_W)) bus ();

   mux_2to1 #(
      .WIDTH (DATA_W)
   ) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   initial begin
      Clk     = 1'b0;
      clk_run = 1'b0;
   end

   always #5 if (clk_run) Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit exceeded");
   end

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".dout_q"}, bus.Dout_q, m_q);
      check({tag, ".sel_q"}, {31'd0, bus.Sel_q}, {31'd0, m_sel});
      check({tag, ".chg"}, {31'd0, bus.Chg}, {31'd0, m_chg});
   endtask

   // Reference behaviour of one rising edge, applied to the model.
   task automatic model_edge();
      word_t ins [2];
      word_t pick;
      ins[0] = bus.D1;
      ins[1] = bus.D2;
      pick   = ins[bus.Sel ? 1 : 0];
      if (bus.En) begin
         m_chg = (pick != m_q);
         m_q   = pick;
         m_sel = bus.Sel;
      end else begin
         m_chg = 1'b0;
      end
   endtask

   initial begin
      word_t ins [2];
      int    sel_w;
      n_vec  = 0;
      n_err  = 0;
      m_q    = '0;
      m_sel  = 1'b0;
      m_chg  = 1'b0;
      Rst_n  = 1'b0;
      bus.En  = 1'b0;
      bus.Sel = 1'b0;
      bus.D1  = '0;
      bus.D2  = '0;
      #1;
      check_regs("reset");

      // Static select with no clock running.
      bus.D1  = 32'd0;
      bus.D2  = 32'd1;
      bus.Sel = 1'b0;
      #1 check("static_sel0", bus.Dout, 32'd0);
      #50 check("static_hold", bus.Dout, 32'd0);
      bus.Sel = 1'b1;
      #1 check("static_sel1", bus.Dout, 32'd1);

      bus.D1  = 32'hDEADBEEF;
      bus.D2  = 32'h12345678;
      bus.Sel = 1'b0;
      #1 check("full_sel0", bus.Dout, 32'hDEADBEEF);
      bus.Sel = 1'b1;
      #1 check("full_sel1", bus.Dout, 32'h12345678);
      bus.Sel = 1'b0;
      #1 check("full_sel0b", bus.Dout, 32'hDEADBEEF);
      check_regs("noclk");

      clk_run = 1'b1;
      @(negedge Clk);
      Rst_n   = 1'b1;
      bus.En  = 1'b1;
      bus.Sel = 1'b1;
      bus.D2  = 32'hA5A5A5A5;
      @(posedge Clk) #1;
      check("cap.dout_q", bus.Dout_q, 32'hA5A5A5A5);
      check("cap.sel_q", {31'd0, bus.Sel_q}, 32'd1);
      check("cap.chg", {31'd0, bus.Chg}, 32'd1);
      @(posedge Clk) #1;
      check("cap_same.chg", {31'd0, bus.Chg}, 32'd0);
      check("cap_same.dout_q", bus.Dout_q, 32'hA5A5A5A5);

      @(negedge Clk);
      bus.En = 1'b0;
      bus.D2 = 32'hFFFFFFFF;
      #1 check("hold.dout", bus.Dout, 32'hFFFFFFFF);
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk) #1;
         check("hold.dout_q", bus.Dout_q, 32'hA5A5A5A5);
         check("hold.chg", {31'd0, bus.Chg}, 32'd0);
      end

      m_q   = 32'hA5A5A5A5;
      m_sel = 1'b1;
      m_chg = 1'b0;

      // Randomized traffic; inputs sometimes reuse the held word so Chg=0 captures occur.
      for (int n = 0; n < 300; n++) begin
         @(negedge Clk);
         bus.D1  = ($urandom_range(0, 3) == 0) ? m_q : word_t'($urandom);
         bus.D2  = ($urandom_range(0, 3) == 0) ? m_q : word_t'($urandom);
         sel_w   = int'($urandom_range(0, 1));
         bus.Sel = sel_w[0];
         bus.En  = ($urandom_range(0, 3) != 0);
         ins[0]  = bus.D1;
         ins[1]  = bus.D2;
         #1 check("rnd.dout", bus.Dout, ins[sel_w]);
         model_edge();
         @(posedge Clk) #1;
         check_regs("rnd");
      end

      // Asynchronous reset between edges.
      @(negedge Clk);
      bus.En  = 1'b1;
      bus.Sel = 1'b0;
      bus.D1  = 32'h13579BDF;
      model_edge();
      @(posedge Clk) #1;
      check_regs("pre_rst");
      @(negedge Clk);
      bus.D2 = 32'h2468ACE0;
      #1 Rst_n = 1'b0;
      #1;
      m_q   = '0;
      m_sel = 1'b0;
      m_chg = 1'b0;
      check_regs("async_rst");
      check("async_rst.dout", bus.Dout, 32'h13579BDF);
      bus.Sel = 1'b1;
      #1 check("async_rst.dout_sel1", bus.Dout, 32'h2468ACE0);
      @(posedge Clk) #1;
      check_regs("rst_held");
      @(negedge Clk);
      Rst_n = 1'b1;
      model_edge();
      @(posedge Clk) #1;
      check_regs("post_rst");

      // Unknown select with agreeing data.
      @(negedge Clk);
      bus.En  = 1'b0;
      bus.D1  = 32'h0000FFFF;
      bus.D2  = 32'h0000FFFF;
      bus.Sel = 1'bx;
      #1 check("selx.dout", bus.Dout, 32'h0000FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mux_2to1
